serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor, the inverse-operation companion to the team's parallel adder in the Tiny Tapeout user design. It latches two unsigned WIDTH-bit operands on a start pulse and produces `a - b` one bit per clock through a borrow-chained full-subtractor cell. It then presents the difference and final borrow with a one-cycle done strobe. It sits behind the top-level `ui_in`/`uo_out` pins; operands come from `ui_in`, and start comes from a `uio_in` bit.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_sub_bit.sv | 11 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned SERSUB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sersub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between the requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SERSUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module serial_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor producing a - b over WIDTH cycles with a done strobe.
// Optional macro SERIAL_SUBTRACTOR_SAT_EN clamps the result to zero on underflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SERSUB_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sersub_state_t    state;
    sersub_state_t    state_next;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] diff_load;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    serial_sub_bit u_bit (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // Result as it will look once the current bit is shifted in at the MSB
    assign res_full = {d_bit, res[WIDTH-1:1]};

    always_comb begin
        diff_load = res_full;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if (br_next) begin
            diff_load = '0;
        end
`endif
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == SHIFT);
            done_q <= (state_next == DONE);
            if (load) begin
                op_a <= bus.a;
                op_b <= bus.b;
                res  <= '0;
                cnt  <= '0;
                br   <= 1'b0;
            end else if (step) begin
                op_a <= {1'b0, op_a[WIDTH-1:1]};
                op_b <= {1'b0, op_b[WIDTH-1:1]};
                res  <= res_full;
                cnt  <= cnt + CNT_W'(1);
                br   <= br_next;
            end
            // Holding registers change only when the final bit lands
            if (last) begin
                diff_q   <= diff_load;
                borrow_q <= br_next;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, latency checks and a result scoreboard.
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
    } res_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    res_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        r.diff   = W'(x - y);
        r.borrow = (x < y);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if (r.borrow) r.diff = '0;
`endif
        return r;
    endfunction

    // Scoreboard consumer: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (bus.busy && bus.done) begin
            total++;
            bad++;
            $display("FAIL busy_and_done: both high at %0t", $time);
        end
        if (bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard at %0t", $time);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("borrow", 32'(bus.borrow), 32'(e.borrow));
            end
        end
    end

    // Busy for W cycles after the accepting edge, then a single done cycle
    task automatic expect_busy_then_done(input string tag);
        for (int i = 0; i < int'(W); i++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_nodone"}, 32'(bus.done), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb);
        res_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        e.diff    = ed;
        e.borrow  = eb;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        expect_busy_then_done("op");
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
        vecs[1] = '{a: 4'd3,  b: 4'd9,  diff: 4'd0,  borrow: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd15, diff: 4'd0,  borrow: 1'b1};
        vecs[6] = '{a: 4'd1,  b: 4'd2,  diff: 4'd0,  borrow: 1'b1};
`else
        vecs[1] = '{a: 4'd3,  b: 4'd9,  diff: 4'd10, borrow: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd15, diff: 4'd1,  borrow: 1'b1};
        vecs[6] = '{a: 4'd1,  b: 4'd2,  diff: 4'd15, borrow: 1'b1};
`endif
        vecs[0] = '{a: 4'd9,  b: 4'd3,  diff: 4'd6,  borrow: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd15, diff: 4'd0,  borrow: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd0,  diff: 4'd15, borrow: 1'b0};
        vecs[5] = '{a: 4'd10, b: 4'd4,  diff: 4'd6,  borrow: 1'b0};

        // Start with reset asserted: must be ignored
        bus.start = 1'b1;
        bus.a     = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow);
        end

        // A few model-checked random operands
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            res_t         m;
            ra = W'($urandom);
            rb = W'($urandom);
            m  = model(ra, rb);
            run_op(ra, rb, m.diff, m.borrow);
        end

        // Start pulsed during busy cycle 2 must be ignored
        begin
            res_t e;
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = 4'd9;
            bus.b     = 4'd3;
            e.diff    = 4'd6;
            e.borrow  = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("ign_busy1", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
            check("ign_busy2", 32'(bus.busy), 32'd1);
            bus.start = 1'b1;
            bus.a     = 4'd1;
            bus.b     = 4'd2;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("ign_busy3", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
            check("ign_busy4", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
            check("ign_done", 32'(bus.done), 32'd1);
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                check("ign_no_second_done", 32'(bus.done), 32'd0);
                check("ign_stays_idle", 32'(bus.busy), 32'd0);
            end
        end

        // Reset during busy cycle 2 abandons the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd12;
        bus.b     = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_diff", 32'(bus.diff), 32'd0);
        check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
        repeat (W + 2) begin
            @(posedge clk); #1;
            check("mid_rst_quiet", 32'({bus.busy, bus.done}), 32'd0);
        end
        run_op(4'd7, 4'd2, 4'd5, 1'b0);

        // Back-to-back: start held high, second operands presented in DONE
        begin
            res_t e;
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = 4'd8;
            bus.b     = 4'd1;
            e.diff    = 4'd7;
            e.borrow  = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            expect_busy_then_done("b2b_first");
            bus.a    = 4'd5;
            bus.b    = 4'd5;
            e.diff   = 4'd0;
            e.borrow = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            bus.start = 1'b0;
            expect_busy_then_done("b2b_second");
            @(negedge clk);
        end

        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
